// File: rtl/sum_serial_if.sv
// sum_serial_if: request/response bundle for the bit-serial adder.
//   start   : load A/B/Ci and begin an addition
//   A, B    : WIDTH-bit operands, sampled on the accepted start edge
//   Ci      : carry-in, sampled with A/B
//   busy    : addition in progress
//   done    : one-cycle pulse, S/Cout just became valid
//   S, Cout : result and carry-out, held until the next completion
//   V       : signed overflow, present only with SUM_SERIAL_OVF_EN
// Modports: master drives requests, slave is the adder.
interface sum_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
`ifdef SUM_SERIAL_OVF_EN
  logic             V;

  modport master (output start, A, B, Ci, input busy, done, S, Cout, V);
  modport slave  (input start, A, B, Ci, output busy, done, S, Cout, V);
`else
  modport master (output start, A, B, Ci, input busy, done, S, Cout);
  modport slave  (input start, A, B, Ci, output busy, done, S, Cout);
`endif
endinterface

// File: rtl/sum_serial.sv
// sum_serial: bit-serial WIDTH-bit ripple adder. One full-adder evaluation
// per clock, LSB first, with the carry kept in a register between bits.
// Operands load in parallel on start; the result is presented in parallel
// together with a single-cycle done pulse.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (beats start on the same edge)
//   bus : sum_serial_if.slave (start/A/B/Ci in, busy/done/S/Cout[/V] out)
//
// Optional feature macro: SUM_SERIAL_OVF_EN adds V, the signed two's-
// complement overflow (carry into MSB xor carry out of MSB), captured and
// held with S/Cout. Without the macro neither the port nor its flop exist.
//
// Timing: the start edge moves IDLE/DONE -> RUN. RUN consumes WIDTH edges,
// one bit each; the edge that handles bit WIDTH-1 publishes S/Cout and moves
// to DONE. DONE lasts one cycle and can itself accept a new start, so
// back-to-back additions complete every WIDTH+1 cycles.
module sum_serial #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  sum_serial_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Single full-adder cell, returned as {carry_out, sum}.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic ci);
    logic s, co;
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
    return {co, s};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;     // operand shift registers, consumed LSB first
  logic [WIDTH-1:0] res_q;        // result shift register, filled from the MSB
  logic             carry_q;      // carry into the bit being processed
  logic [CW-1:0]    cnt_q;        // index of the bit being processed
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
`ifdef SUM_SERIAL_OVF_EN
  logic             v_q;
`endif

  logic             load, step, last;
  logic             s_bit, c_out;
  logic [WIDTH-1:0] res_next;

  // A new request is taken only when no addition is in flight; DONE counts
  // as free so there is no bubble between consecutive additions.
  assign load = bus.start & ((state_q == IDLE) | (state_q == DONE));
  assign step = (state_q == RUN);
  assign last = step & (cnt_q == LAST);

  assign {c_out, s_bit} = fa(a_q[0], b_q[0], carry_q);
  assign res_next       = {s_bit, res_q[WIDTH-1:1]};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = bus.start ? RUN : IDLE;
      RUN:     state_d = (cnt_q == LAST) ? DONE : RUN;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef SUM_SERIAL_OVF_EN
      v_q     <= 1'b0;
`endif
    end else if (load) begin
      a_q     <= bus.A;
      b_q     <= bus.B;
      res_q   <= '0;
      carry_q <= bus.Ci;
      cnt_q   <= '0;
    end else if (step) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      res_q   <= res_next;
      carry_q <= c_out;
      cnt_q   <= cnt_q + 1'b1;
      // Outputs update only here, so they never expose a partial sum.
      if (last) begin
        s_q    <= res_next;
        cout_q <= c_out;
`ifdef SUM_SERIAL_OVF_EN
        // carry_q is the carry into the MSB on this final bit.
        v_q    <= carry_q ^ c_out;
`endif
      end
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
`ifdef SUM_SERIAL_OVF_EN
  assign bus.V    = v_q;
`endif

endmodule
